hash_sched: RTL and testbench

- Work scheduler and golden-nonce collector for NUM_CORES hashcore instances sharing one midstate/data job.
- Accepts a new job through a valid/ready handshake and double-buffers it. It then sequences cores through load, run and drain, and counts the nonce sweep.
- Each core's one-cycle golden-nonce strobe is captured and round-robin merged into a tagged output FIFO read by the comms layer.

---
 rtl/hash_sched_pkg.sv | 11 +
 rtl/hash_sched_gn_fifo.sv | 43 ++++
 rtl/hash_sched.sv | 132 +++++++++++++
 tb/tb_hash_sched.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hash_sched_pkg.sv
// hash_sched_pkg: FSM encoding, widths and FIFO entry layout for the hash scheduler
package hash_sched_pkg;
    localparam int GN_W = 32;
    localparam int ID_W = 8;
    localparam int ENT_W = GN_W + ID_W;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;
    typedef struct packed {
        logic [GN_W-1:0] gn;
        logic [ID_W-1:0] id;
    } gn_entry_t;
endpackage

// File: rtl/hash_sched_gn_fifo.sv
// gn_fifo: first-word fall-through FIFO of tagged golden nonces with async reset
module gn_fifo
    import hash_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  gn_entry_t din,
    output gn_entry_t dout,
    output logic      full,
    output logic      empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    gn_entry_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic do_push, do_pop;
    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign do_push = push && (!full || do_pop);
    assign dout = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/hash_sched.sv
// hash_sched: double-buffered job scheduler and round-robin golden-nonce collector
module hash_sched
    import hash_sched_pkg::*;
#(
    parameter int          NUM_CORES    = 2,
    parameter int          FIFO_DEPTH   = 8,
    parameter int unsigned SWEEP_CYCLES = 32'h8000_0000,
    parameter int          DRAIN_CYCLES = 66
) (
    input  logic                      hash_clk,
    input  logic                      reset,
    input  logic                      work_valid,
    output logic                      work_ready,
    input  logic [255:0]              work_midstate,
    input  logic [95:0]               work_data,
    input  logic [ID_W-1:0]           work_id,
    output logic [255:0]              core_midstate,
    output logic [95:0]               core_data,
    output logic                      core_run,
    output logic                      core_restart,
    input  logic [GN_W*NUM_CORES-1:0] core_gn,
    input  logic [NUM_CORES-1:0]      core_gn_match,
    output logic [GN_W-1:0]           gn_out,
    output logic [ID_W-1:0]           gn_id,
    output logic                      gn_valid,
    input  logic                      gn_ready,
    output logic                      sweep_done,
    output logic                      overflow
);
    localparam int PW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [31:0] SWEEP_LAST = 32'(SWEEP_CYCLES - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
    state_t state, state_nx;
    logic shadow_full;
    logic [255:0] shadow_midstate;
    logic [95:0] shadow_data;
    logic [ID_W-1:0] shadow_id, cur_id;
    logic [31:0] sweep_cnt;
    logic [DW-1:0] drain_cnt;
    logic sweep_end, drain_end, accept;
    gn_entry_t hold [NUM_CORES];
    gn_entry_t head;
    logic [NUM_CORES-1:0] pending, grant, hit;
    logic [PW-1:0] ptr, sel, idx;
    logic found, push, full, empty;
    assign work_ready = !shadow_full;
    assign accept = work_valid && work_ready;
    assign core_run = state == RUN || state == DRAIN;
    assign core_restart = state == LOAD;
    assign sweep_end = sweep_cnt == SWEEP_LAST;
    assign drain_end = drain_cnt == DRAIN_LAST;
    assign hit = core_run ? core_gn_match : '0;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = shadow_full ? LOAD : IDLE;
            LOAD:    state_nx = RUN;
            RUN:     state_nx = (sweep_end || shadow_full) ? DRAIN : RUN;
            DRAIN:   state_nx = !drain_end ? DRAIN : shadow_full ? LOAD : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge hash_clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            shadow_full <= 1'b0;
            shadow_midstate <= '0;
            shadow_data <= '0;
            shadow_id <= '0;
            core_midstate <= '0;
            core_data <= '0;
            cur_id <= '0;
            sweep_cnt <= '0;
            drain_cnt <= '0;
            sweep_done <= 1'b0;
        end else begin
            state <= state_nx;
            sweep_cnt <= state == RUN ? sweep_cnt + 32'd1 : '0;
            drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
            sweep_done <= state == DRAIN && drain_end && !shadow_full;
            if (state == LOAD) shadow_full <= 1'b0;
            else if (accept) shadow_full <= 1'b1;
            if (accept) {shadow_midstate, shadow_data, shadow_id} <= {work_midstate, work_data, work_id};
            if (state == LOAD) {core_midstate, core_data, cur_id} <= {shadow_midstate, shadow_data, shadow_id};
        end
    // round-robin: first pending core at or after ptr
    always_comb begin
        found = 1'b0;
        sel = '0;
        idx = '0;
        grant = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_CORES);
            if (!found && pending[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
        push = found && !full;
        if (push) grant[sel] = 1'b1;
    end
    always_ff @(posedge hash_clk or posedge reset)
        if (reset) begin
            pending <= '0;
            ptr <= '0;
            overflow <= 1'b0;
            for (int k = 0; k < NUM_CORES; k++) hold[k] <= '0;
        end else begin
            overflow <= overflow || |(hit & pending & ~grant);
            if (push) ptr <= PW'((int'(sel) + 1) % NUM_CORES);
            // a strobe on a still-pending core keeps the older value
            for (int k = 0; k < NUM_CORES; k++)
                if (hit[k] && (!pending[k] || grant[k])) begin
                    pending[k] <= 1'b1;
                    hold[k] <= {core_gn[GN_W*k +: GN_W], cur_id};
                end else if (grant[k]) pending[k] <= 1'b0;
        end
    gn_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(hash_clk),
        .rst(reset),
        .push(push),
        .pop(gn_ready),
        .din(hold[sel]),
        .dout(head),
        .full(full),
        .empty(empty)
    );
    assign gn_out = head.gn;
    assign gn_id = head.id;
    assign gn_valid = !empty;
endmodule

// File: tb/tb_hash_sched.sv
// tb_hash_sched: directed checks of job sequencing, match capture, arbitration and FIFO
module tb_hash_sched;
    logic hash_clk = 1'b0;
    logic reset = 1'b1;
    logic work_valid = 1'b0;
    logic work_ready;
    logic [255:0] work_midstate = '0;
    logic [95:0] work_data = '0;
    logic [7:0] work_id = '0;
    logic [255:0] core_midstate;
    logic [95:0] core_data;
    logic core_run, core_restart;
    logic [63:0] core_gn = '0;
    logic [1:0] core_gn_match = '0;
    logic [31:0] gn_out;
    logic [7:0] gn_id;
    logic gn_valid;
    logic gn_ready = 1'b0;
    logic sweep_done, overflow;
    int checks = 0;
    int failures = 0;
    logic [255:0] m1, m2, m3;
    logic [95:0] d1, d2, d3;
    int runs, sd, sd_at, n;
    always #5 hash_clk = ~hash_clk;
    hash_sched #(.NUM_CORES(2), .FIFO_DEPTH(8), .SWEEP_CYCLES(100), .DRAIN_CYCLES(66)) dut (
        .hash_clk(hash_clk), .reset(reset),
        .work_valid(work_valid), .work_ready(work_ready),
        .work_midstate(work_midstate), .work_data(work_data), .work_id(work_id),
        .core_midstate(core_midstate), .core_data(core_data),
        .core_run(core_run), .core_restart(core_restart),
        .core_gn(core_gn), .core_gn_match(core_gn_match),
        .gn_out(gn_out), .gn_id(gn_id), .gn_valid(gn_valid), .gn_ready(gn_ready),
        .sweep_done(sweep_done), .overflow(overflow)
    );
    task automatic step(input int cyc);
        repeat (cyc) @(posedge hash_clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic offer(input logic [7:0] id, input logic [255:0] ms, input logic [95:0] d);
        work_valid = 1'b1;
        work_id = id;
        work_midstate = ms;
        work_data = d;
        step(1);
        work_valid = 1'b0;
    endtask
    task automatic strobe(input logic [1:0] m, input logic [31:0] g0, input logic [31:0] g1);
        core_gn_match = m;
        core_gn = {g1, g0};
        step(1);
        core_gn_match = '0;
    endtask
    initial begin
        m1 = {8{32'hA5A5_0011}};
        m2 = {8{32'h5A5A_0022}};
        m3 = {8{32'hC3C3_0033}};
        d1 = {3{32'hD1D1_0011}};
        d2 = {3{32'hD2D2_0022}};
        d3 = {3{32'hD3D3_0033}};
        step(2);
        chk("rst_work_ready", work_ready, 1);
        chk("rst_core_run", core_run, 0);
        chk("rst_restart", core_restart, 0);
        chk("rst_gn_valid", gn_valid, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sweep_done", sweep_done, 0);
        reset = 1'b0;
        step(1);
        // single job, full sweep and drain
        work_valid = 1'b1;
        work_id = 8'h11;
        work_midstate = m1;
        work_data = d1;
        chk("offer_ready", work_ready, 1);
        step(1);
        work_valid = 1'b0;
        chk("shadow_full_ready", work_ready, 0);
        step(1);
        chk("load_restart", core_restart, 1);
        chk("load_run", core_run, 0);
        step(1);
        chk("run_run", core_run, 1);
        chk("run_restart", core_restart, 0);
        chk("run_midstate", core_midstate, m1);
        chk("run_data", core_data, d1);
        chk("run_ready", work_ready, 1);
        runs = 1;
        sd = 0;
        sd_at = 0;
        for (int i = 2; i <= 200; i++) begin
            step(1);
            if (core_run) runs++;
            if (sweep_done) begin
                sd++;
                sd_at = i;
            end
        end
        chk("run_cycles", runs, 166);
        chk("sweep_done_count", sd, 1);
        chk("sweep_done_at", sd_at, 167);
        chk("idle_run", core_run, 0);
        // preemption during RUN, match during DRAIN tagged with old id
        offer(8'h11, m1, d1);
        step(2);
        step(20);
        offer(8'h22, m2, d2);
        chk("preempt_ready", work_ready, 0);
        step(1);
        chk("drain_run", core_run, 1);
        step(10);
        strobe(2'b01, 32'h0000_1234, 32'h0);
        step(1);
        chk("drain_gn_valid", gn_valid, 1);
        chk("drain_gn_out", gn_out, 32'h0000_1234);
        chk("drain_gn_id", gn_id, 8'h11);
        chk("drain_hold_ms", core_midstate, m1);
        step(53);
        chk("drain_last_run", core_run, 1);
        step(1);
        chk("reload_restart", core_restart, 1);
        chk("reload_no_sd", sweep_done, 0);
        step(1);
        chk("reload_midstate", core_midstate, m2);
        chk("reload_data", core_data, d2);
        gn_ready = 1'b1;
        step(1);
        gn_ready = 1'b0;
        chk("pop_empty", gn_valid, 0);
        // simultaneous strobes with ptr=1
        strobe(2'b11, 32'hA, 32'hB);
        step(2);
        chk("rr_first", gn_out, 32'hB);
        chk("rr_first_id", gn_id, 8'h22);
        gn_ready = 1'b1;
        step(1);
        chk("rr_second", gn_out, 32'hA);
        step(1);
        gn_ready = 1'b0;
        chk("rr_empty", gn_valid, 0);
        strobe(2'b11, 32'hA, 32'hB);
        step(1);
        chk("rr_ptr_end", gn_out, 32'hB);
        gn_ready = 1'b1;
        step(2);
        gn_ready = 1'b0;
        chk("rr_drained", gn_valid, 0);
        // FIFO fill and overflow
        for (int i = 0; i < 10; i++) begin
            strobe(2'b01, 32'h100 + i, 32'h0);
            step(1);
            if (i == 8) chk("ovf_before", overflow, 0);
        end
        chk("ovf_set", overflow, 1);
        chk("full_head", gn_out, 32'h100);
        n = 0;
        while (core_run && n < 300) begin
            step(1);
            n++;
        end
        chk("idle_reached", core_run, 0);
        chk("sweep_done_b", sweep_done, 1);
        chk("ovf_sticky", overflow, 1);
        gn_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("pop_gn", gn_out, 32'h100 + i);
            chk("pop_id", gn_id, 8'h22);
            step(1);
        end
        gn_ready = 1'b0;
        chk("pop_all_empty", gn_valid, 0);
        // strobes in IDLE are ignored
        strobe(2'b01, 32'hDEAD, 32'h0);
        step(1);
        chk("idle_ignore", gn_valid, 0);
        // asynchronous reset mid-run
        offer(8'h33, m3, d3);
        step(2);
        strobe(2'b01, 32'h1, 32'h0);
        step(1);
        strobe(2'b01, 32'h2, 32'h0);
        step(1);
        strobe(2'b01, 32'h3, 32'h0);
        step(2);
        chk("pre_rst_valid", gn_valid, 1);
        chk("pre_rst_id", gn_id, 8'h33);
        offer(8'h44, m1, d1);
        chk("pre_rst_ready", work_ready, 0);
        chk("pre_rst_run", core_run, 1);
        reset = 1'b1;
        #1;
        chk("arst_gn_valid", gn_valid, 0);
        chk("arst_core_run", core_run, 0);
        chk("arst_work_ready", work_ready, 1);
        chk("arst_overflow", overflow, 0);
        step(2);
        reset = 1'b0;
        step(1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
